// File: rtl/pc_unit_mt.sv
// Multi-thread program counter unit. It keeps one PC per hardware thread and selects the fetch thread round-robin.
// Optional exception capture (srr0/srr0_tid, exc_* ports) is enabled by defining PC_UNIT_EXC_EN.
module pc_unit_mt #(
    parameter int unsigned             PC_WIDTH    = 32,
    parameter int unsigned             THREADS     = 2,
    parameter int unsigned             TID_W       = 1,
    parameter logic [PC_WIDTH-1:0]     RESET_VEC   = PC_WIDTH'(32'h0000_0100),
    parameter int unsigned             INC         = 4,
    parameter int unsigned             BOOT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic [THREADS-1:0]  thread_en,
    input  logic                redir_en,
    input  logic [TID_W-1:0]    redir_tid,
    input  logic [PC_WIDTH-1:0] redir_pc,
`ifdef PC_UNIT_EXC_EN
    input  logic                exc_req,
    input  logic [TID_W-1:0]    exc_tid,
    input  logic [PC_WIDTH-1:0] exc_vec,
    output logic [PC_WIDTH-1:0] srr0,
    output logic [TID_W-1:0]    srr0_tid,
`endif
    output logic [PC_WIDTH-1:0] pc,
    output logic [TID_W-1:0]    pc_tid,
    output logic                pc_valid
);

    localparam int unsigned IDX_W = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam int unsigned CNT_W = $clog2(BOOT_CYCLES + 1);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TID_W-1:0]    cur_tid_q, cur_tid_d;
    logic [PC_WIDTH-1:0] pc_q [THREADS];
    logic [PC_WIDTH-1:0] pc_d [THREADS];
`ifdef PC_UNIT_EXC_EN
    logic [PC_WIDTH-1:0] srr0_q, srr0_d;
    logic [TID_W-1:0]    srr0_tid_q, srr0_tid_d;
`endif

    logic                cur_en;
    logic [PC_WIDTH-1:0] pc_sel;
    logic                any_en;
    logic                issue;
    logic                nxt_found;
    logic [TID_W-1:0]    nxt_tid;
    logic [TID_W-1:0]    low_tid;

    // Selected thread's PC and enable.
    always_comb begin
        cur_en = 1'b0;
        pc_sel = pc_q[0];
        for (int t = 0; t < THREADS; t++) begin
            if (cur_tid_q == TID_W'(t)) begin
                cur_en = thread_en[IDX_W'(t)];
                pc_sel = pc_q[IDX_W'(t)];
            end
        end
    end

    // Next enabled thread after cur_tid (cyclic), and lowest enabled thread.
    always_comb begin
        nxt_found = 1'b0;
        nxt_tid   = cur_tid_q;
        for (int k = 1; k <= THREADS; k++) begin
            if (!nxt_found && thread_en[IDX_W'((int'(cur_tid_q) + k) % THREADS)]) begin
                nxt_found = 1'b1;
                nxt_tid   = TID_W'((int'(cur_tid_q) + k) % THREADS);
            end
        end
        low_tid = '0;
        for (int t = THREADS - 1; t >= 0; t--) begin
            if (thread_en[IDX_W'(t)]) low_tid = TID_W'(t);
        end
    end

    assign any_en   = |thread_en;
    assign pc_valid = (state_q == ST_RUN) && cur_en;
    assign issue    = pc_valid && !stall;
    assign pc       = pc_sel;
    assign pc_tid   = cur_tid_q;
`ifdef PC_UNIT_EXC_EN
    assign srr0     = srr0_q;
    assign srr0_tid = srr0_tid_q;
`endif

    // Next-state, thread rotation and per-thread PC update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_tid_d = cur_tid_q;
`ifdef PC_UNIT_EXC_EN
        srr0_d     = srr0_q;
        srr0_tid_d = srr0_tid_q;
`endif
        case (state_q)
            ST_BOOT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BOOT_CYCLES - 1)) state_d = any_en ? ST_RUN : ST_HALT;
            end
            ST_RUN: begin
                if (!any_en)     state_d   = ST_HALT;
                else if (!stall) cur_tid_d = nxt_tid;
            end
            ST_HALT: begin
                if (any_en) begin
                    state_d   = ST_RUN;
                    cur_tid_d = low_tid;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        // Priority per thread: exception over redirect over increment.
        for (int t = 0; t < THREADS; t++) begin
            pc_d[IDX_W'(t)] = pc_q[IDX_W'(t)];
            if (issue && cur_tid_q == TID_W'(t))
                pc_d[IDX_W'(t)] = pc_q[IDX_W'(t)] + PC_WIDTH'(INC);
            if (redir_en && redir_tid == TID_W'(t))
                pc_d[IDX_W'(t)] = redir_pc;
`ifdef PC_UNIT_EXC_EN
            if (exc_req && exc_tid == TID_W'(t)) begin
                srr0_d          = pc_q[IDX_W'(t)];
                srr0_tid_d      = exc_tid;
                pc_d[IDX_W'(t)] = exc_vec;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            cnt_q     <= '0;
            cur_tid_q <= '0;
            for (int t = 0; t < THREADS; t++) pc_q[IDX_W'(t)] <= RESET_VEC;
`ifdef PC_UNIT_EXC_EN
            srr0_q     <= '0;
            srr0_tid_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_tid_q <= cur_tid_d;
            for (int t = 0; t < THREADS; t++) pc_q[IDX_W'(t)] <= pc_d[IDX_W'(t)];
`ifdef PC_UNIT_EXC_EN
            srr0_q     <= srr0_d;
            srr0_tid_q <= srr0_tid_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_unit_mt.sv
// Bench for pc_unit_mt: directed vector table, reset/exception sequences, then random traffic against a reference model.
module tb_pc_unit_mt;

    localparam int THREADS = 2;
    localparam int TID_W   = 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               stall;
    logic [THREADS-1:0] thread_en;
    logic               redir_en;
    logic [TID_W-1:0]   redir_tid;
    logic [31:0]        redir_pc;
    logic [31:0]        pc;
    logic [TID_W-1:0]   pc_tid;
    logic               pc_valid;
`ifdef PC_UNIT_EXC_EN
    logic               exc_req;
    logic [TID_W-1:0]   exc_tid;
    logic [31:0]        exc_vec;
    logic [31:0]        srr0;
    logic [TID_W-1:0]   srr0_tid;
`endif

    always #5 clk = ~clk;

    pc_unit_mt dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .thread_en(thread_en),
        .redir_en(redir_en), .redir_tid(redir_tid), .redir_pc(redir_pc),
`ifdef PC_UNIT_EXC_EN
        .exc_req(exc_req), .exc_tid(exc_tid), .exc_vec(exc_vec),
        .srr0(srr0), .srr0_tid(srr0_tid),
`endif
        .pc(pc), .pc_tid(pc_tid), .pc_valid(pc_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 = booting, 1 = fetching, 2 = halted.
    int               m_mode;
    int               m_boot_left;
    logic [31:0]      m_pc [THREADS];
    logic [TID_W-1:0] m_tid;
    logic [31:0]      m_srr0;
    logic [TID_W-1:0] m_srr0_tid;

    function automatic logic m_en(input logic [THREADS-1:0] en, input int idx);
        logic [THREADS-1:0] sh;
        sh = en >> idx;
        return sh[0];
    endfunction

    task automatic model_edge();
        logic [31:0] nxt_pc [THREADS];
        logic        iss;
        if (!rst_n) begin
            m_mode = 0; m_boot_left = 2; m_tid = '0;
            m_srr0 = '0; m_srr0_tid = '0;
            for (int t = 0; t < THREADS; t++) m_pc[t] = 32'h100;
            return;
        end
        iss = (m_mode == 1) && m_en(thread_en, int'(m_tid)) && !stall;
        nxt_pc = m_pc;
        if (iss) nxt_pc[m_tid] = m_pc[m_tid] + 32'd4;
        if (redir_en && int'(redir_tid) < THREADS) nxt_pc[redir_tid] = redir_pc;
`ifdef PC_UNIT_EXC_EN
        if (exc_req && int'(exc_tid) < THREADS) begin
            m_srr0 = m_pc[exc_tid]; m_srr0_tid = exc_tid; nxt_pc[exc_tid] = exc_vec;
        end
`endif
        if (m_mode == 0) begin
            m_boot_left--;
            if (m_boot_left == 0) m_mode = (thread_en != 0) ? 1 : 2;
        end else if (m_mode == 1) begin
            if (thread_en == 0) m_mode = 2;
            else if (!stall) begin
                for (int k = THREADS; k >= 1; k--)
                    if (m_en(thread_en, (int'(m_tid) + k) % THREADS)) m_tid = TID_W'((int'(m_tid) + k) % THREADS);
            end
        end else if (thread_en != 0) begin
            m_mode = 1;
            for (int t = THREADS - 1; t >= 0; t--) if (m_en(thread_en, t)) m_tid = TID_W'(t);
        end
        m_pc = nxt_pc;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_pc, input logic [31:0] e_tid, input logic e_v);
        check({tag, "_pc"}, pc, e_pc);
        check({tag, "_tid"}, 32'(pc_tid), e_tid);
        check({tag, "_valid"}, 32'(pc_valid), 32'(e_v));
    endtask

    typedef struct {
        logic             stall;
        logic [1:0]       en;
        logic             re;
        logic [TID_W-1:0] rt;
        logic [31:0]      rp;
        logic [31:0]      e_pc;
        logic [31:0]      e_tid;
        logic             e_v;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic s, input logic [1:0] en, input logic re, input logic rt,
                        input logic [31:0] rp, input logic [31:0] ep, input logic [31:0] et, input logic ev);
        vec_t v;
        v.stall = s; v.en = en; v.re = re; v.rt = rt; v.rp = rp;
        v.e_pc = ep; v.e_tid = et; v.e_v = ev;
        vq.push_back(v);
    endtask

    initial begin
        // Boot, round-robin, stall, redirects, wrap, halt and re-enable.
        addv(0, 2'b11, 0, 0, 0,            32'h100,        0, 0);
        addv(0, 2'b11, 0, 0, 0,            32'h100,        0, 0);
        addv(0, 2'b11, 0, 0, 0,            32'h100,        0, 1);
        addv(0, 2'b11, 0, 0, 0,            32'h100,        1, 1);
        addv(0, 2'b11, 0, 0, 0,            32'h104,        0, 1);
        addv(1, 2'b11, 0, 0, 0,            32'h104,        1, 1);
        addv(1, 2'b11, 0, 0, 0,            32'h104,        1, 1);
        addv(1, 2'b11, 0, 0, 0,            32'h104,        1, 1);
        addv(0, 2'b11, 0, 0, 0,            32'h104,        1, 1);
        addv(0, 2'b11, 1, 1, 32'h2000,     32'h108,        0, 1);
        addv(0, 2'b11, 0, 0, 0,            32'h2000,       1, 1);
        addv(0, 2'b11, 1, 0, 32'h3000,     32'h10C,        0, 1);
        addv(0, 2'b11, 0, 0, 0,            32'h2004,       1, 1);
        addv(0, 2'b11, 1, 0, 32'hFFFF_FFFC, 32'h3000,      0, 1);
        addv(0, 2'b01, 0, 0, 0,            32'h2008,       1, 0);
        addv(0, 2'b01, 0, 0, 0,            32'hFFFF_FFFC,  0, 1);
        addv(0, 2'b01, 0, 0, 0,            32'h0,          0, 1);
        addv(0, 2'b01, 0, 0, 0,            32'h4,          0, 1);
        addv(0, 2'b00, 0, 0, 0,            32'h8,          0, 0);
        addv(0, 2'b00, 0, 0, 0,            32'h8,          0, 0);
        addv(0, 2'b10, 0, 0, 0,            32'h8,          0, 0);
        addv(0, 2'b10, 0, 0, 0,            32'h2008,       1, 1);
        addv(0, 2'b11, 0, 0, 0,            32'h200C,       1, 1);
        addv(0, 2'b11, 0, 0, 0,            32'h8,          0, 1);

        rst_n = 1'b0; stall = 1'b0; thread_en = 2'b11;
        redir_en = 1'b0; redir_tid = '0; redir_pc = '0;
`ifdef PC_UNIT_EXC_EN
        exc_req = 1'b0; exc_tid = '0; exc_vec = '0;
`endif
        #1;
        cycle();
        rst_n = 1'b1;

        foreach (vq[i]) begin
            stall = vq[i].stall; thread_en = vq[i].en;
            redir_en = vq[i].re; redir_tid = vq[i].rt; redir_pc = vq[i].rp;
            #1;
            chk_out($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_tid, vq[i].e_v);
            cycle();
        end
        redir_en = 1'b0;

        // Reset mid-run with a pending redirect: redirect is discarded, boot restarts.
        rst_n = 1'b0; redir_en = 1'b1; redir_tid = '0; redir_pc = 32'h5555_0000; thread_en = 2'b11;
        cycle();
        rst_n = 1'b1; redir_en = 1'b0;
        #1; chk_out("rst0", 32'h100, 0, 0);
        cycle(); chk_out("rst1", 32'h100, 0, 0);
        cycle(); chk_out("rst2", 32'h100, 0, 1);
        cycle(); chk_out("rst3", 32'h100, 1, 1);
        cycle();
        // A low pulse between edges is never sampled.
        rst_n = 1'b0; #2; rst_n = 1'b1; #1;
        chk_out("glitch0", 32'h104, 0, 1);
        cycle(); chk_out("glitch1", 32'h104, 1, 1);

`ifdef PC_UNIT_EXC_EN
        rst_n = 1'b0; cycle(); rst_n = 1'b1; #1;
        check("srr0_rst", srr0, 32'h0);
        check("srr0_tid_rst", 32'(srr0_tid), 32'h0);
        cycle(); cycle(); cycle(); cycle();
        exc_req = 1'b1; exc_tid = '0; exc_vec = 32'h700;
        redir_en = 1'b1; redir_tid = '0; redir_pc = 32'h900;
        #1; chk_out("exc_pre", 32'h104, 0, 1);
        cycle();
        exc_req = 1'b0; redir_en = 1'b0; #1;
        check("exc_srr0", srr0, 32'h104);
        check("exc_srr0_tid", 32'(srr0_tid), 32'h0);
        chk_out("exc_t1", 32'h104, 1, 1);
        cycle(); chk_out("exc_t0", 32'h700, 0, 1);
`endif

        // Randomized traffic checked against the reference model.
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            stall     = ($urandom_range(0, 9) < 3);
            thread_en = ($urandom_range(0, 9) < 6) ? 2'b11 : THREADS'($urandom_range(0, 3));
            redir_en  = ($urandom_range(0, 9) == 0);
            redir_tid = TID_W'($urandom_range(0, 1));
            redir_pc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
`ifdef PC_UNIT_EXC_EN
            exc_req = ($urandom_range(0, 19) == 0);
            exc_tid = TID_W'($urandom_range(0, 1));
            exc_vec = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            check("rnd_srr0", srr0, m_srr0);
            check("rnd_srr0_tid", 32'(srr0_tid), 32'(m_srr0_tid));
`endif
            #1;
            chk_out("rnd", m_pc[m_tid], 32'(m_tid), (m_mode == 1) && m_en(thread_en, int'(m_tid)));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
